// File: rtl/ocp_slave_mem.sv
// ocp_slave_mem: OCP target terminating the interconnect's OCP master port.
// Tagged RD/WR commands hit a word-addressed register file; every read (and
// every write when WRESP_EN) queues one {SResp, Sdata, STagID} response in a
// small FIFO that drains under MRespAccept backpressure.
// Ports:
//   clk, rstn            clock / async active-low reset
//   MCmd, MAddr, MTagID  command, byte address, tag
//   Mdata, MDataValid    write data and its valid
//   MRespAccept          master takes the current response
//   SCmdAccept           command accepted this cycle (combinational)
//   SDataAccept          write data accepted this cycle (combinational)
//   SResp, Sdata, STagID FIFO head; NULL / zeros when empty
module ocp_slave_mem #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int TW       = 4,
  parameter int DEPTH    = 16,
  parameter int RQ_DEPTH = 4,
  parameter int WRESP_EN = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [2:0]    MCmd,
  input  logic [AW-1:0] MAddr,
  input  logic [TW-1:0] MTagID,
  input  logic [DW-1:0] Mdata,
  input  logic          MDataValid,
  input  logic          MRespAccept,
  output logic          SCmdAccept,
  output logic          SDataAccept,
  output logic [1:0]    SResp,
  output logic [DW-1:0] Sdata,
  output logic [TW-1:0] STagID
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = $clog2(RQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [1:0] RSP_NULL = 2'd0, RSP_DVA = 2'd1, RSP_ERR = 2'd3;
  localparam logic WR_RESP = (WRESP_EN != 0);

  typedef enum logic {IDLE, WAIT_DATA} state_t;
  typedef struct packed {
    logic [1:0]    resp;
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } rsp_t;

  state_t        state;
  logic [AW-1:0] lat_addr;
  logic [TW-1:0] lat_tag;
  logic [DW-1:0] mem [DEPTH];
  rsp_t          rq  [RQ_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] count;

  logic cmd_wr, cmd_rd, room, rd_acc, wr_ok, wr_done, push, pop;
  logic [AW-1:0] cur_addr;
  logic [TW-1:0] cur_tag;
  logic [IW-1:0] cur_idx;
  logic          cur_err;
  rsp_t          push_e;

  assign cmd_wr = (MCmd == 3'd1);
  assign cmd_rd = (MCmd == 3'd2);
  // Only IDLE ever accepts, and in IDLE no write is pending, so the slot
  // reserved for a WAIT_DATA write is already accounted for in count.
  assign room   = (count < CW'(RQ_DEPTH));

  // WAIT_DATA works on the latched command, IDLE on the live one.
  assign cur_addr = (state == WAIT_DATA) ? lat_addr : MAddr;
  assign cur_tag  = (state == WAIT_DATA) ? lat_tag  : MTagID;
  assign cur_idx  = cur_addr[2 +: IW];
  assign cur_err  = (cur_addr[1:0] != 2'b00) || ((cur_addr >> 2) >= AW'(DEPTH));

  always_comb begin
    rd_acc      = 1'b0;
    wr_ok       = 1'b0;
    wr_done     = 1'b0;
    SCmdAccept  = 1'b0;
    SDataAccept = 1'b0;
    if (state == IDLE) begin
      rd_acc      = cmd_rd && room;
      wr_ok       = cmd_wr && (room || !WR_RESP);
      SCmdAccept  = rd_acc || wr_ok;
      SDataAccept = wr_ok && MDataValid;
      wr_done     = wr_ok && MDataValid;
    end else begin
      SDataAccept = MDataValid;
      wr_done     = MDataValid;
    end
  end

  assign push        = rd_acc || (WR_RESP && wr_done);
  assign pop         = (count != '0) && MRespAccept;
  assign push_e.resp = cur_err ? RSP_ERR : RSP_DVA;
  assign push_e.data = (rd_acc && !cur_err) ? mem[cur_idx] : '0;
  assign push_e.tag  = cur_tag;

  assign SResp  = (count != '0) ? rq[rp].resp : RSP_NULL;
  assign Sdata  = (count != '0) ? rq[rp].data : '0;
  assign STagID = (count != '0) ? rq[rp].tag  : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      lat_addr <= '0;
      lat_tag  <= '0;
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++)    mem[i] <= '0;
      for (int i = 0; i < RQ_DEPTH; i++) rq[i]  <= '0;
    end else begin
      if (wr_done && !cur_err) mem[cur_idx] <= Mdata;
      if (push) begin
        rq[wp] <= push_e;
        wp     <= wp + PW'(1);
      end
      if (pop) rp <= rp + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      case (state)
        IDLE: if (wr_ok && !MDataValid) begin
          lat_addr <= MAddr;
          lat_tag  <= MTagID;
          state    <= WAIT_DATA;
        end
        WAIT_DATA: if (MDataValid) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  // The room check and the WAIT_DATA reservation make these unreachable.
  always @(posedge clk) begin
    if (rstn) begin
      assert (!(push && !pop && count == CW'(RQ_DEPTH))) else $error("rq overflow");
      assert (!(pop && count == '0)) else $error("rq underflow");
    end
  end
endmodule

// File: tb/tb_ocp_slave_mem.sv
module tb_ocp_slave_mem;
  logic        clk = 1'b0;
  logic        rstn;
  logic [2:0]  MCmd;
  logic [31:0] MAddr, Mdata;
  logic [3:0]  MTagID;
  logic        MDataValid, MRespAccept;
  logic        scmd, sdat, scmd2, sdat2;
  logic [1:0]  sresp, sresp2;
  logic [31:0] sdata, sdata2;
  logic [3:0]  stag, stag2;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  ocp_slave_mem dut (
    .clk(clk), .rstn(rstn), .MCmd(MCmd), .MAddr(MAddr), .MTagID(MTagID),
    .Mdata(Mdata), .MDataValid(MDataValid), .MRespAccept(MRespAccept),
    .SCmdAccept(scmd), .SDataAccept(sdat), .SResp(sresp), .Sdata(sdata), .STagID(stag));

  ocp_slave_mem #(.WRESP_EN(0)) dut_p (
    .clk(clk), .rstn(rstn), .MCmd(MCmd), .MAddr(MAddr), .MTagID(MTagID),
    .Mdata(Mdata), .MDataValid(MDataValid), .MRespAccept(MRespAccept),
    .SCmdAccept(scmd2), .SDataAccept(sdat2), .SResp(sresp2), .Sdata(sdata2), .STagID(stag2));

  // inputs change at posedge+1, combinational outputs are checked at +2
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [2:0] c, input logic [31:0] a, input logic [3:0] t,
                       input logic [31:0] d, input logic dv);
    MCmd = c; MAddr = a; MTagID = t; Mdata = d; MDataValid = dv; #1;
  endtask

  task automatic idle();
    drive(3'd0, 32'h0, 4'h0, 32'h0, 1'b0);
  endtask

  // one-cycle read; afterwards the read response is at the head
  task automatic rd(input logic [31:0] a, input logic [3:0] t);
    drive(3'd2, a, t, 32'h0, 1'b0);
    tick(); idle();
  endtask

  task automatic test_reset();
    rstn = 1'b0; MRespAccept = 1'b0; idle();
    repeat (2) tick();
    total++; if (sresp !== 2'd0)  begin bad++; $display("FAIL reset_sresp got=%0d exp=0", sresp); end
    total++; if (scmd !== 1'b0 || sdat !== 1'b0) begin bad++; $display("FAIL reset_accept got=%b%b exp=00", scmd, sdat); end
    total++; if (sdata !== 32'h0 || stag !== 4'h0) begin bad++; $display("FAIL reset_data got=%h/%h exp=0/0", sdata, stag); end
    rstn = 1'b1; tick();
  endtask

  task automatic test_write_read();
    MRespAccept = 1'b1;
    drive(3'd1, 32'h8, 4'd3, 32'hA5A5_0001, 1'b1);
    total++; if (scmd !== 1'b1 || sdat !== 1'b1) begin bad++; $display("FAIL wr_accept got=%b%b exp=11", scmd, sdat); end
    tick(); idle();
    total++; if (sresp !== 2'd1 || stag !== 4'd3 || sdata !== 32'h0) begin bad++; $display("FAIL wr_resp got=%0d/%0d/%h exp=1/3/0", sresp, stag, sdata); end
    drive(3'd2, 32'h8, 4'd9, 32'h0, 1'b0);
    total++; if (scmd !== 1'b1) begin bad++; $display("FAIL rd_accept got=%b exp=1", scmd); end
    tick(); idle();
    total++; if (sresp !== 2'd1 || stag !== 4'd9 || sdata !== 32'hA5A5_0001) begin bad++; $display("FAIL rd_resp got=%0d/%0d/%h exp=1/9/a5a50001", sresp, stag, sdata); end
    tick();
    total++; if (sresp !== 2'd0) begin bad++; $display("FAIL rd_drain got=%0d exp=0", sresp); end
  endtask

  task automatic test_wait_data();
    drive(3'd1, 32'h4, 4'd2, 32'h0, 1'b0);
    total++; if (scmd !== 1'b1 || sdat !== 1'b0) begin bad++; $display("FAIL wd_cmd got=%b%b exp=10", scmd, sdat); end
    tick();
    // a read offered while data is outstanding must be refused
    for (int i = 0; i < 2; i++) begin
      drive(3'd2, 32'h8, 4'd7, 32'h0, 1'b0);
      total++; if (scmd !== 1'b0 || sdat !== 1'b0 || sresp !== 2'd0) begin bad++; $display("FAIL wd_wait%0d got=%b%b/%0d exp=00/0", i, scmd, sdat, sresp); end
      tick();
    end
    drive(3'd0, 32'h0, 4'd0, 32'h1234, 1'b1);
    total++; if (scmd !== 1'b0 || sdat !== 1'b1) begin bad++; $display("FAIL wd_data got=%b%b exp=01", scmd, sdat); end
    tick(); idle();
    total++; if (sresp !== 2'd1 || stag !== 4'd2) begin bad++; $display("FAIL wd_resp got=%0d/%0d exp=1/2", sresp, stag); end
    tick();
    rd(32'h4, 4'd7);
    total++; if (sresp !== 2'd1 || sdata !== 32'h1234 || stag !== 4'd7) begin bad++; $display("FAIL wd_readback got=%0d/%h/%0d exp=1/1234/7", sresp, sdata, stag); end
    tick();
  endtask

  task automatic test_backpressure();
    MRespAccept = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(3'd2, 32'h8, 4'(i), 32'h0, 1'b0);
      total++; if (scmd !== (i < 4)) begin bad++; $display("FAIL bp_accept%0d got=%b exp=%b", i, scmd, (i < 4)); end
      if (i < 4) tick();
    end
    tick();
    total++; if (sresp !== 2'd1 || stag !== 4'd0 || sdata !== 32'hA5A5_0001) begin bad++; $display("FAIL bp_hold got=%0d/%0d/%h exp=1/0/a5a50001", sresp, stag, sdata); end
    MRespAccept = 1'b1; #1;
    total++; if (scmd !== 1'b0) begin bad++; $display("FAIL bp_full_pop got=%b exp=0", scmd); end
    tick();
    total++; if (scmd !== 1'b1 || stag !== 4'd1) begin bad++; $display("FAIL bp_reaccept got=%b/%0d exp=1/1", scmd, stag); end
    tick(); idle();
    for (int t = 2; t <= 4; t++) begin
      total++; if (sresp !== 2'd1 || stag !== 4'(t)) begin bad++; $display("FAIL bp_order%0d got=%0d/%0d exp=1/%0d", t, sresp, stag, t); end
      tick();
    end
    total++; if (sresp !== 2'd0) begin bad++; $display("FAIL bp_empty got=%0d exp=0", sresp); end
  endtask

  task automatic test_addr_err();
    MRespAccept = 1'b1;
    rd(32'h40, 4'd5);
    total++; if (sresp !== 2'd3 || sdata !== 32'h0 || stag !== 4'd5) begin bad++; $display("FAIL err_range got=%0d/%h/%0d exp=3/0/5", sresp, sdata, stag); end
    rd(32'h6, 4'd6);
    total++; if (sresp !== 2'd3 || sdata !== 32'h0 || stag !== 4'd6) begin bad++; $display("FAIL err_align got=%0d/%h/%0d exp=3/0/6", sresp, sdata, stag); end
    drive(3'd1, 32'h40, 4'd1, 32'hDEAD_BEEF, 1'b1);
    tick(); idle();
    total++; if (sresp !== 2'd3 || stag !== 4'd1) begin bad++; $display("FAIL err_wr got=%0d/%0d exp=3/1", sresp, stag); end
    tick();
    // 0x40 would alias word 0 if the range check were missing
    rd(32'h0, 4'd8);
    total++; if (sresp !== 2'd1 || sdata !== 32'h0) begin bad++; $display("FAIL err_alias got=%0d/%h exp=1/0", sresp, sdata); end
    rd(32'h8, 4'd8);
    total++; if (sdata !== 32'hA5A5_0001) begin bad++; $display("FAIL err_keep got=%h exp=a5a50001", sdata); end
    tick();
  endtask

  task automatic test_reset_mid();
    MRespAccept = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(3'd2, 32'h8, 4'(i), 32'h0, 1'b0); tick();
    end
    drive(3'd1, 32'hC, 4'd4, 32'h0, 1'b0); tick(); idle();
    total++; if (sresp !== 2'd1 || stag !== 4'd1) begin bad++; $display("FAIL rm_pre got=%0d/%0d exp=1/1", sresp, stag); end
    rstn = 1'b0; #1;
    total++; if (sresp !== 2'd0) begin bad++; $display("FAIL rm_async got=%0d exp=0", sresp); end
    repeat (2) tick();
    rstn = 1'b1; MRespAccept = 1'b1;
    drive(3'd0, 32'h0, 4'd0, 32'h5555, 1'b1);
    total++; if (sdat !== 1'b0) begin bad++; $display("FAIL rm_pending got=%b exp=0", sdat); end
    tick(); idle(); tick();
    total++; if (sresp !== 2'd0) begin bad++; $display("FAIL rm_stale got=%0d exp=0", sresp); end
    rd(32'h8, 4'd2);
    total++; if (sresp !== 2'd1 || sdata !== 32'h0) begin bad++; $display("FAIL rm_cleared got=%0d/%h exp=1/0", sresp, sdata); end
    tick();
  endtask

  task automatic test_posted();
    MRespAccept = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(3'd1, 32'(i * 4), 4'(i), 32'h100 + 32'(i), 1'b1);
      total++; if (scmd2 !== 1'b1 || sdat2 !== 1'b1) begin bad++; $display("FAIL po_accept%0d got=%b%b exp=11", i, scmd2, sdat2); end
      tick();
    end
    idle();
    total++; if (sresp2 !== 2'd0) begin bad++; $display("FAIL po_noresp got=%0d exp=0", sresp2); end
    MRespAccept = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rd(32'(i * 4), 4'(i));
      total++; if (sresp2 !== 2'd1 || sdata2 !== 32'h100 + 32'(i)) begin bad++; $display("FAIL po_read%0d got=%0d/%h exp=1/%h", i, sresp2, sdata2, 32'h100 + 32'(i)); end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wait_data();
    test_backpressure();
    test_addr_err();
    test_reset_mid();
    test_posted();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ocp_slave_mem.md
Name: ocp_slave_mem

Overview:
- OCP target (responder) terminating the OCP master port driven by the AXI-to-OCP interconnect.
- Accepts read and write commands with tags into a word-addressed register-file memory.
- Queues one response per command (DVA or ERR) with the echoed tag, and honours MRespAccept backpressure.
- Used as the bench's OCP memory model and as a synthesizable scratchpad.

Parameters:
- AW, 32, MAddr width in bits
- DW, 32, data width in bits
- TW, 4, MTagID/STagID width in bits
- DEPTH, 16, memory words (power of 2, minimum 2); word index = MAddr[2 +: log2(DEPTH)]
- RQ_DEPTH, 4, response FIFO entries (power of 2)
- WRESP_EN, 1, when 1 writes produce a response; when 0 writes are posted

Ports:
- clk  in  1  clock, all state on rising edge
- rstn  in  1  asynchronous, active-low reset
- MCmd  in  3  OCP command; 0 IDLE, 1 WR, 2 RD, others treated as IDLE
- MAddr  in  AW  byte address
- MTagID  in  TW  command tag
- Mdata  in  DW  write data
- MDataValid  in  1  write data valid
- MRespAccept  in  1  master accepts the current response
- SCmdAccept  out  1  command accepted this cycle
- SDataAccept  out  1  write data accepted this cycle
- SResp  out  2  0 NULL, 1 DVA, 3 ERR
- Sdata  out  DW  read data; 0 for writes and errors
- STagID  out  TW  tag of the response

Behaviour:
- Reset (rstn low, asynchronous):
  - All outputs 0; SResp = NULL.
  - FIFO emptied, count = 0, FSM = IDLE, memory cleared to 0.
  - Reset asserted mid-transaction drops pending writes and queued responses; no response is ever issued for them.
- Address check: error when MAddr[1:0] != 0 or MAddr >> 2 >= DEPTH.
- room = (count < RQ_DEPTH). count is the value before any same-cycle pop, so a full FIFO never accepts, even while popping.
- FSM IDLE:
  - RD with room:
    - SCmdAccept = 1.
    - At this edge, push {DVA, mem[idx], MTagID}, or {ERR, 0, MTagID} on address error.
  - WR, MDataValid = 1, and room (or WRESP_EN = 0):
    - SCmdAccept = 1 and SDataAccept = 1.
    - Write mem[idx] = Mdata unless address error.
    - Push {DVA or ERR, 0, MTagID} when WRESP_EN = 1.
  - WR, MDataValid = 0, and room (or WRESP_EN = 0):
    - SCmdAccept = 1.
    - Latch MAddr and MTagID, then go to WAIT_DATA.
  - Any command without room: SCmdAccept = 0. The master holds the command; no state change.
  - MDataValid with no WR in IDLE: SDataAccept = 0; data ignored.
- FSM WAIT_DATA:
  - SCmdAccept = 0; SDataAccept = MDataValid.
  - On MDataValid: write latched index (unless latched address error), push response when WRESP_EN, return to IDLE.
  - Room was reserved at command acceptance, so this push never overflows.
  - To guarantee this, room in IDLE is count + pending_write < RQ_DEPTH.
- SCmdAccept and SDataAccept are combinational from current state, inputs and count. One command per cycle.
- Response output:
  - SResp, Sdata, STagID are driven from the FIFO head; SResp = NULL when empty.
  - Pop at the edge where SResp != NULL and MRespAccept = 1. The head holds stable until popped.
- Latency: a read accepted at edge k with an empty FIFO shows DVA in the cycle after edge k. Responses return strictly in acceptance order.
- Simultaneous push and pop: both occur and count is unchanged; a pop from one entry plus a push leaves the new entry at the head.
- Read-after-write: a write completing at edge k is visible to a read accepted at edge k+1.
- Counters:
  - FIFO pointers wrap modulo RQ_DEPTH; count ranges 0..RQ_DEPTH.
  - Counter overflow and underflow are impossible by construction; assert this in simulation.

Test Plan:
- Reset, then WR addr 0x8 data 0xA5A5_0001 tag 3 with MDataValid, MRespAccept = 1 → SCmdAccept = SDataAccept = 1; next cycle SResp = DVA, STagID = 3. Then RD addr 0x8 tag 9 → SResp = DVA, Sdata = 0xA5A5_0001, STagID = 9, one cycle after acceptance.
- WR addr 0x4 tag 2 without data, data 0x1234 three cycles later → SCmdAccept pulses once; FSM in WAIT_DATA for 3 cycles; SDataAccept = 1 on the data cycle; DVA tag 2 follows. Read addr 0x4 returns 0x1234.
- MRespAccept = 0, issue 5 reads tags 0..4 → first 4 accepted, 5th sees SCmdAccept = 0 and is held. SResp = DVA with tag 0 held stable. Release MRespAccept → tags 0,1,2,3,4 returned in order, then SResp = NULL.
- RD addr 0x40 (DEPTH 16) tag 5 and RD addr 0x6 tag 6 → ERR with Sdata 0 for both. WR to 0x40 leaves all memory words unchanged.
- Queue 3 responses, assert rstn low mid-stream for 2 cycles, release → SResp = NULL immediately, no stale responses, read of addr 0x8 returns 0.
- WRESP_EN = 0: 6 back-to-back writes with MRespAccept = 0 → all accepted, no response produced; readback data correct.
